// File: rtl/sync_phase_splitter_if.sv
// Bundles the sync input, per-output enables and all splitter outputs.
// master = the splitter itself, slave = whatever drives sync/en and consumes outputs.
// Purely combinational wiring; no storage.
interface sync_phase_splitter_if #(
  parameter int N_OUT = 4,
  parameter int CNT_W = 10
);
  logic             sync_in;
  logic [N_OUT-1:0] en;
  logic [N_OUT-1:0] sync_out;
  logic             locked;
  logic [CNT_W-1:0] period;
  logic             sync_lost;

  modport master (
    input  sync_in, en,
    output sync_out, locked, period, sync_lost
  );

  modport slave (
    output sync_in, en,
    input  sync_out, locked, period, sync_lost
  );
endinterface

// File: rtl/sync_phase_splitter.sv
// Locks onto an external sync square wave and emits N_OUT staggered copies.
// Latency: sync_in high at E0 -> sync_out[0] rises after E3; decisions once per edge.
// No backpressure: free-running, one period measurement per detected rising edge.
module sync_phase_splitter #(
  parameter int N_OUT    = 4,
  parameter int CNT_W    = 10,
  parameter int TOL      = 4,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 255
) (
  input logic                   clk,
  input logic                   rst,
  sync_phase_splitter_if.master bus
);

  localparam int SH   = $clog2(N_OUT);
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] PC_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TOL_V     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  LOCK_V    = MC_W'(LOCK_CNT);

  typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

  state_t           state, state_nx;
  logic             s1, s2, s3;
  logic             rise;
  logic [CNT_W-1:0] pc, ph;
  logic [MC_W-1:0]  mcnt, mcnt_nx;
  logic [CNT_W-1:0] pprev, pprev_nx;
  logic             have, have_nx;
  logic [CNT_W-1:0] period_q, period_nx;
  logic             lost_q, lost_nx;
  logic [N_OUT-1:0] so_q, so_nx;
  logic [N_OUT-1:0] en_q, en_q_nx;
  logic [CNT_W-1:0] off [N_OUT];
  logic             timeout, match_prev, match_per;

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign rise    = s2 & ~s3;
  assign timeout = (pc == TIMEOUT_V);
  // A saturated count means the real period is unknown, so it never matches.
  assign match_prev = (pc != PC_MAX) && (abs_diff(pc, pprev) <= TOL_V);
  assign match_per  = (pc != PC_MAX) && (abs_diff(pc, period_q) <= TOL_V);

  // Synchronize sync_in, run the period counter and the phase counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
      pc <= '0;
      ph <= '0;
    end else begin
      s1 <= bus.sync_in;
      s2 <= s1;
      s3 <= s2;
      if (rise)              pc <= CNT_W'(1);
      else if (pc != PC_MAX) pc <= pc + CNT_W'(1);
      // Phase free-runs at the current period if the next edge is late.
      if (rise)
        ph <= '0;
      else if (((CNT_W+1)'(ph) + (CNT_W+1)'(1)) >= {1'b0, period_q})
        ph <= '0;
      else
        ph <= ph + CNT_W'(1);
    end
  end

  // Lock FSM state and acquisition bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_UNLOCKED;
      mcnt     <= '0;
      pprev    <= '0;
      have     <= 1'b0;
      period_q <= '0;
    end else begin
      state    <= state_nx;
      mcnt     <= mcnt_nx;
      pprev    <= pprev_nx;
      have     <= have_nx;
      period_q <= period_nx;
    end
  end

  // Next-state decision: an edge always takes priority over a timeout.
  always_comb begin
    state_nx  = state;
    mcnt_nx   = mcnt;
    pprev_nx  = pprev;
    have_nx   = have;
    period_nx = period_q;
    lost_nx   = 1'b0;
    unique case (state)
      ST_UNLOCKED: begin
        if (rise) begin
          state_nx = ST_ACQUIRE;
          mcnt_nx  = '0;
          have_nx  = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (rise) begin
          pprev_nx = pc;
          have_nx  = 1'b1;
          if (have) begin
            if (match_prev) begin
              mcnt_nx = mcnt + MC_W'(1);
              if (mcnt + MC_W'(1) == LOCK_V) begin
                state_nx  = ST_LOCKED;
                period_nx = pc;
              end
            end else begin
              mcnt_nx = '0;
            end
          end
        end else if (timeout) begin
          state_nx = ST_UNLOCKED;
        end
      end
      ST_LOCKED: begin
        if (rise) begin
          if (match_per) begin
            period_nx = pc;
          end else begin
            state_nx = ST_UNLOCKED;
            lost_nx  = 1'b1;
          end
        end else if (timeout) begin
          state_nx = ST_UNLOCKED;
          lost_nx  = 1'b1;
        end
      end
      default: state_nx = ST_UNLOCKED;
    endcase
  end

  // Per-output phase offsets, k/N_OUT of the locked period.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      off[k] = CNT_W'(((CNT_W+SH)'(k) * (CNT_W+SH)'(period_q)) >> SH);
    end
  end

  // Output decode: enables latch only at each output's pulse start, and
  // outputs drop on the same clock that leaves LOCKED.
  always_comb begin
    logic             stay;
    logic             en_eff;
    logic [CNT_W-1:0] rel;
    stay    = (state == ST_LOCKED) && (state_nx == ST_LOCKED);
    so_nx   = '0;
    en_q_nx = en_q;
    for (int k = 0; k < N_OUT; k++) begin
      en_eff     = (ph == off[k]) ? bus.en[k] : en_q[k];
      rel        = (ph >= off[k]) ? (ph - off[k]) : (ph + period_q - off[k]);
      en_q_nx[k] = en_eff;
      so_nx[k]   = stay & en_eff & (rel < (period_q >> 1));
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      so_q   <= '0;
      en_q   <= '0;
      lost_q <= 1'b0;
    end else begin
      so_q   <= so_nx;
      en_q   <= en_q_nx;
      lost_q <= lost_nx;
    end
  end

  assign bus.sync_out  = so_q;
  assign bus.locked    = (state == ST_LOCKED);
  assign bus.period    = period_q;
  assign bus.sync_lost = lost_q;

endmodule

// File: tb/tb_sync_phase_splitter.sv
// Randomized bench for sync_phase_splitter against an edge-history reference model.
// Model tracks cycles since the last edge and the list of measured periods.
// Every cycle all outputs are compared to the model.
module tb_sync_phase_splitter;
  localparam int N_OUT    = 4;
  localparam int CNT_W    = 10;
  localparam int TOL      = 4;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 255;
  localparam int PMAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [N_OUT-1:0] en_drv = '0;

  sync_phase_splitter_if #(.N_OUT(N_OUT), .CNT_W(CNT_W)) bus ();

  sync_phase_splitter #(
    .N_OUT(N_OUT), .CNT_W(CNT_W), .TOL(TOL), .LOCK_CNT(LOCK_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_d [3];          // sync_in history as seen through the synchronizer
  int m_since;          // cycles since last edge, saturating (measured period)
  int m_age;            // cycles since last edge, unbounded (phase position)
  int m_state;          // 0 unlocked, 1 acquiring, 2 locked
  int m_hist [$];       // periods measured since acquisition began
  int m_per;
  bit m_lost;
  bit m_enq [N_OUT];
  logic [N_OUT-1:0] m_so;

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic bit agree(input int p, input int ref_p);
    return (p != PMAX) && (absd(p, ref_p) <= TOL);
  endfunction

  // Length of the trailing run of mutually agreeing consecutive measurements.
  function automatic int run_len();
    int n = 0;
    for (int i = m_hist.size() - 1; i >= 1; i--) begin
      if (agree(m_hist[i], m_hist[i-1])) n++;
      else break;
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_d[i] = 0;
    m_since = 0; m_age = 0; m_state = 0; m_per = 0; m_lost = 0; m_so = '0;
    m_hist.delete();
    for (int k = 0; k < N_OUT; k++) m_enq[k] = 0;
  endtask

  task automatic model_step(input bit sin, input logic [N_OUT-1:0] e);
    bit rise;
    int ns, nper, ph, off, rel;
    bit lost, eff;
    rise = (m_d[1] == 1) && (m_d[2] == 0);
    ns   = m_state;
    nper = m_per;
    lost = 0;
    ph   = (m_per == 0) ? 0 : (m_age % m_per);
    case (m_state)
      0: if (rise) begin ns = 1; m_hist.delete(); end
      1: begin
        if (rise) begin
          m_hist.push_back(m_since);
          if (run_len() >= LOCK_CNT) begin ns = 2; nper = m_since; end
        end else if (m_since == TIMEOUT) ns = 0;
      end
      default: begin
        if (rise) begin
          if (agree(m_since, m_per)) nper = m_since;
          else begin ns = 0; lost = 1; end
        end else if (m_since == TIMEOUT) begin
          ns = 0; lost = 1;
        end
      end
    endcase
    for (int k = 0; k < N_OUT; k++) begin
      off = (k * m_per) / N_OUT;
      rel = (m_per == 0) ? 0 : (((ph - off) % m_per) + m_per) % m_per;
      eff = (ph == off) ? e[k] : m_enq[k];
      m_enq[k] = eff;
      m_so[k]  = (m_state == 2) && (ns == 2) && eff && (rel < m_per / 2);
    end
    m_age   = rise ? 0 : m_age + 1;
    m_since = rise ? 1 : ((m_since + 1 > PMAX) ? PMAX : m_since + 1);
    m_d[2] = m_d[1]; m_d[1] = m_d[0]; m_d[0] = sin;
    m_state = ns;
    m_per   = nper;
    m_lost  = lost;
  endtask

  // ---------------- stimulus ----------------
  task automatic tick(input bit sin);
    bus.sync_in = sin;
    bus.en      = en_drv;
    @(posedge clk);
    model_step(sin, en_drv);
    #1;
    check("sync_out",  32'(bus.sync_out),  32'(m_so));
    check("locked",    32'(bus.locked),    32'(m_state == 2));
    check("period",    32'(bus.period),    32'(m_per));
    check("sync_lost", 32'(bus.sync_lost), 32'(m_lost));
  endtask

  task automatic periods(input int per, input int n, input int jit, input int en_rate);
    int p;
    for (int i = 0; i < n; i++) begin
      p = per;
      if (jit > 0) p = per + $urandom_range(2 * jit) - jit;
      for (int c = 0; c < p; c++) begin
        if (en_rate > 0 && $urandom_range(en_rate - 1) == 0) en_drv = N_OUT'($urandom);
        tick(c < p / 2);
      end
    end
  endtask

  task automatic do_reset();
    #4 rst = 1'b0;
    #1;
    check("rst_sync_out",  32'(bus.sync_out),  0);
    check("rst_locked",    32'(bus.locked),    0);
    check("rst_period",    32'(bus.period),    0);
    check("rst_sync_lost", 32'(bus.sync_lost), 0);
    model_reset();
    #3 rst = 1'b1;
  endtask

  initial begin
    bus.sync_in = 1'b0;
    bus.en      = '0;
    model_reset();
    #5;
    check("init_sync_out",  32'(bus.sync_out),  0);
    check("init_locked",    32'(bus.locked),    0);
    check("init_period",    32'(bus.period),    0);
    check("init_sync_lost", 32'(bus.sync_lost), 0);
    #20 rst = 1'b1;

    // Lock and phasing at 184.
    en_drv = 4'hF;
    periods(184, 8, 0, 0);
    check("lock184_locked", 32'(bus.locked), 1);
    check("lock184_period", 32'(bus.period), 184);

    // Jitter within tolerance keeps lock.
    for (int i = 0; i < 4; i++) begin
      periods(182, 1, 0, 0);
      periods(186, 1, 0, 0);
    end
    check("jitter_locked", 32'(bus.locked), 1);

    // Enable gating: drop en[2] mid-pulse, later restore it.
    for (int c = 0; c < 184; c++) begin
      if (c == 130) en_drv[2] = 1'b0;
      tick(c < 92);
    end
    periods(184, 2, 0, 0);
    en_drv[2] = 1'b1;
    periods(184, 2, 0, 0);

    // Loss of sync.
    for (int c = 0; c < 300; c++) tick(1'b0);
    check("loss_locked", 32'(bus.locked), 0);

    // Relock then period jump to 150.
    periods(184, 8, 0, 0);
    periods(150, 10, 0, 0);
    check("jump_period", 32'(bus.period), 150);

    // Reset while an output pulse is high.
    for (int c = 0; c < 30; c++) tick(1'b1);
    do_reset();
    for (int c = 0; c < 62; c++) tick(1'b1);
    for (int c = 0; c < 75; c++) tick(1'b0);
    periods(150, 8, 0, 0);

    // Randomized periods, jitter, enables and gaps.
    for (int r = 0; r < 8; r++) begin
      periods($urandom_range(240, 40), $urandom_range(9, 4), $urandom_range(2, 0), 50);
      if ($urandom_range(2) == 0) begin
        for (int c = 0; c < $urandom_range(300, 100); c++) tick(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
